adc_result_receiver: RTL and testbench

- Digital consumer at the output end of the SAR ADC conversion interface.
- Detects each end-of-conversion (EOC) and captures the NUM_BITS conversion code.
- Buffers captured codes in a small FIFO and presents them to downstream logic over a valid/ready stream.
- Reports overrun: a sticky flag plus a saturating drop counter. Sits beside the ADC top, on the same clock domain.

---
 rtl/adc_rx_pkg.sv | 23 ++
 rtl/adc_sync_fifo.sv | 58 +++++
 rtl/adc_result_receiver.sv | 75 +++++++
 tb/tb_adc_result_receiver.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_rx_pkg.sv
// Shared types and helpers for the ADC result receiver.
// Default sizes mirror the SAR ADC conversion interface.
package adc_rx_pkg;

    localparam int DEF_NUM_BITS   = 4;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_DROP_CNT_W = 8;
    localparam int PTR_W          = $clog2(DEF_DEPTH);

    typedef logic [DEF_NUM_BITS-1:0]   code_t;
    typedef logic [DEF_DROP_CNT_W-1:0] drop_cnt_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] max;
        max = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/adc_sync_fifo.sv
// Single-clock FIFO with wrap-bit binary pointers.
// dout reads as zero while empty so stale or unknown storage never leaks out.
module adc_sync_fifo
    import adc_rx_pkg::*;
#(
    parameter int WIDTH = DEF_NUM_BITS,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot a full push needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_result_receiver.sv
// Captures one ADC code per EOC rising edge into a FIFO and streams it out,
// counting samples lost to a full buffer.
module adc_result_receiver
    import adc_rx_pkg::*;
#(
    parameter int NUM_BITS   = DEF_NUM_BITS,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int DROP_CNT_W = DEF_DROP_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_BITS-1:0]      adc_code,
    input  logic                     adc_eoc,
    output logic [NUM_BITS-1:0]      m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     overrun,
    input  logic                     clr_overrun,
    output logic [DROP_CNT_W-1:0]    drop_cnt,
    output logic [$clog2(DEPTH):0]   level
);

    logic eoc_q;
    logic capture_evt;
    logic pop;
    logic push;
    logic drop;
    logic full;
    logic empty;

    assign capture_evt = adc_eoc & ~eoc_q & enable;
    assign m_valid     = ~empty;
    assign pop         = m_valid & m_ready;
    assign push        = capture_evt & (~full | pop);
    assign drop        = capture_evt & full & ~pop;

    adc_sync_fifo #(
        .WIDTH (NUM_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (adc_code),
        .full  (full),
        .pop   (pop),
        .dout  (m_data),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eoc_q <= 1'b0;
        end else begin
            eoc_q <= adc_eoc;
        end
    end

    // A drop coinciding with a clear restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun  <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_overrun) begin
            overrun  <= drop;
            drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
        end else if (drop) begin
            overrun  <= 1'b1;
            drop_cnt <= DROP_CNT_W'(sat_inc(32'(drop_cnt), DROP_CNT_W));
        end
    end

endmodule

// File: tb/tb_adc_result_receiver.sv
// Randomized and directed bench for adc_result_receiver against a
// queue-based model of the capture/stream/overrun rules.
module tb_adc_result_receiver;

    localparam int NB   = 4;
    localparam int DEP  = 8;
    localparam int DW   = 2;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [NB-1:0] adc_code;
    logic          adc_eoc;
    logic [NB-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          overrun;
    logic          clr_overrun;
    logic [DW-1:0] drop_cnt;
    logic [3:0]    level;

    int n_cmp = 0;
    int n_err = 0;

    int q[$];
    bit m_eoc;
    bit m_ovr;
    int m_drop;

    adc_result_receiver #(
        .NUM_BITS   (NB),
        .DEPTH      (DEP),
        .DROP_CNT_W (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .adc_code    (adc_code),
        .adc_eoc     (adc_eoc),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .drop_cnt    (drop_cnt),
        .level       (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_eoc  = 0;
        m_ovr  = 0;
        m_drop = 0;
    endtask

    task automatic check_all();
        check("m_valid", 32'(m_valid), 32'(q.size() > 0));
        check("m_data", 32'(m_data), (q.size() > 0) ? q[0] : 0);
        check("level", 32'(level), q.size());
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("drop_cnt", 32'(drop_cnt), m_drop);
    endtask

    task automatic tick();
        bit cap;
        bit pp;
        bit fl;
        bit dr;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            cap   = adc_eoc && !m_eoc && enable;
            pp    = (q.size() > 0) && m_ready;
            fl    = (q.size() == DEP);
            m_eoc = adc_eoc;
            dr    = cap && fl && !pp;
            if (pp) void'(q.pop_front());
            if (cap && !dr) q.push_back(int'(adc_code));
            if (clr_overrun) begin
                m_ovr  = dr;
                m_drop = dr ? 1 : 0;
            end else if (dr) begin
                m_ovr  = 1;
                m_drop = (m_drop < DMAX) ? m_drop + 1 : DMAX;
            end
        end
        #1;
        check_all();
    endtask

    task automatic pulse(input int code);
        adc_code = NB'(code);
        adc_eoc  = 1'b1;
        tick();
        adc_eoc  = 1'b0;
        adc_code = NB'($urandom);
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        enable      = 1'b1;
        adc_code    = '0;
        adc_eoc     = 1'b0;
        m_ready     = 1'b0;
        clr_overrun = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_valid", 32'(m_valid), 0);
        check("rst_level", 32'(level), 0);
        rst_n = 1'b1;
        tick();

        // single conversion, EOC held three cycles
        m_ready  = 1'b1;
        adc_code = 4'hA;
        adc_eoc  = 1'b1;
        tick();
        check("t1_data", 32'(m_data), 32'hA);
        check("t1_valid", 32'(m_valid), 1);
        tick();
        check("t1_once", 32'(m_valid), 0);
        tick();
        adc_eoc = 1'b0;
        repeat (2) tick();
        check("t1_level", 32'(level), 0);

        // backpressure fill beyond depth
        m_ready = 1'b0;
        for (int i = 1; i <= 10; i++) pulse(i);
        check("t2_level", 32'(level), 8);
        check("t2_ovr", 32'(overrun), 1);
        check("t2_drop", 32'(drop_cnt), 2);
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("t2_beat", 32'(m_data), i);
            tick();
        end
        check("t2_empty", 32'(m_valid), 0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("t2_clr", 32'(overrun), 0);

        // full with simultaneous pop and capture
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) pulse(i);
        adc_code = 4'hF;
        adc_eoc  = 1'b1;
        m_ready  = 1'b1;
        tick();
        check("t3_ovr", 32'(overrun), 0);
        check("t3_level", 32'(level), 8);
        adc_eoc = 1'b0;
        m_ready = 1'b0;
        tick();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("t3_last", 32'(m_data), 32'hF);
            tick();
        end

        // enable gating
        m_ready  = 1'b0;
        enable   = 1'b0;
        adc_code = 4'h3;
        adc_eoc  = 1'b1;
        tick();
        enable = 1'b1;
        repeat (2) tick();
        check("t4_none", 32'(level), 0);
        adc_eoc = 1'b0;
        tick();
        pulse(5);
        check("t4_data", 32'(m_data), 32'h5);
        m_ready = 1'b1;
        tick();

        // drop saturation and clear
        m_ready = 1'b0;
        for (int i = 0; i < 14; i++) pulse(i);
        check("t5_sat", 32'(drop_cnt), DMAX);
        clr_overrun = 1'b1;
        tick();
        check("t5_clr_ovr", 32'(overrun), 0);
        check("t5_clr_cnt", 32'(drop_cnt), 0);
        adc_eoc = 1'b1;
        tick();
        clr_overrun = 1'b0;
        adc_eoc     = 1'b0;
        check("t5_co_ovr", 32'(overrun), 1);
        check("t5_co_cnt", 32'(drop_cnt), 1);
        m_ready = 1'b1;
        repeat (9) tick();

        // async reset mid-stream
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) pulse(i + 9);
        check("t6_pre", 32'(level), 5);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(m_valid), 0);
        check("t6_level", 32'(level), 0);
        check("t6_ovr", 32'(overrun), 0);
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        adc_code = 4'h7;
        adc_eoc  = 1'b1;
        tick();
        check("t6_first", 32'(m_data), 32'h7);
        adc_eoc = 1'b0;
        m_ready = 1'b1;
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            enable      = ($urandom_range(0, 9) != 0);
            adc_eoc     = ($urandom_range(0, 2) == 0) ? ~adc_eoc : adc_eoc;
            adc_code    = NB'($urandom);
            m_ready     = ($urandom_range(0, 3) == 0);
            clr_overrun = ($urandom_range(0, 40) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
